// File: rtl/seq_alu_core.sv
// Handshaked unsigned ALU with iterative MUL/DIV/MOD engines and a persistent previous-result register.
// Optional saturation of ADD/SUB/MUL overflow when SEQ_ALU_SAT_EN is defined.
module seq_alu_core #(
    parameter int WIDTH  = 16,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] prev_result,
    output logic             err,
    output logic             busy
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int ITERS = WIDTH / UNROLL;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int W2    = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_MOD  = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;
    localparam logic [3:0] OP_SUB  = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;
    localparam logic [3:0] OP_SLL  = 4'd14;
    localparam logic [3:0] OP_CLR  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [W2-1:0]    x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic             fire_out;
    logic             accept;
    logic             is_iter_op;
    logic [WIDTH-1:0] prev_eff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [W2-1:0]    it_x;
    logic [WIDTH-1:0] it_y;
    logic [W2-1:0]    it_acc;
    logic [WIDTH:0]   it_rem;
    logic [WIDTH-1:0] it_res;
    logic             it_err;

    assign fire_out = (state_q == S_DONE) && out_ready;
    assign in_ready = (state_q == S_IDLE) || fire_out;
    assign accept   = in_valid && in_ready;
    // A NOP accepted back-to-back must see the result being consumed now.
    assign prev_eff = fire_out ? result_q : prev_q;
    assign is_iter_op = (opcode == OP_MUL) ||
                        (((opcode == OP_DIV) || (opcode == OP_MOD)) && (b != '0));

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_err = 1'b0;
        case (opcode)
            OP_NOP:  alu_res = prev_eff;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_XNOR: alu_res = ~(a ^ b);
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_err = sum[WIDTH];
`ifdef SEQ_ALU_SAT_EN
                if (sum[WIDTH]) alu_res = ONES;
`endif
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_err = dif[WIDTH];
`ifdef SEQ_ALU_SAT_EN
                if (dif[WIDTH]) alu_res = '0;
`endif
            end
            OP_SRL:  alu_res = a >> b[SHW-1:0];
            OP_SLL:  alu_res = a << b[SHW-1:0];
            // Only reached for a zero divisor.
            OP_DIV: begin
                alu_res = ONES;
                alu_err = 1'b1;
            end
            OP_MOD: begin
                alu_res = a;
                alu_err = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        it_x   = x_q;
        it_y   = y_q;
        it_acc = acc_q;
        it_rem = '0;
        for (int j = 0; j < UNROLL; j++) begin
            if (op_q == OP_MUL) begin
                if (it_y[0]) it_acc = it_acc + it_x;
                it_x = it_x << 1;
                it_y = it_y >> 1;
            end else begin
                // Restoring step: quotient bits shift in from the low half of x.
                it_rem = {it_acc[WIDTH-1:0], it_x[WIDTH-1]};
                it_x   = it_x << 1;
                if (it_rem >= {1'b0, it_y}) begin
                    it_rem  = it_rem - {1'b0, it_y};
                    it_x[0] = 1'b1;
                end
                it_acc = {{WIDTH{1'b0}}, it_rem[WIDTH-1:0]};
            end
        end
        it_err = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_res = it_acc[WIDTH-1:0];
                it_err = |it_acc[W2-1:WIDTH];
`ifdef SEQ_ALU_SAT_EN
                if (it_err) it_res = ONES;
`endif
            end
            OP_DIV:  it_res = it_x[WIDTH-1:0];
            default: it_res = it_acc[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        prev_d   = prev_q;

        case (state_q)
            S_ITER: begin
                x_d   = it_x;
                y_d   = it_y;
                acc_d = it_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITERS - 1)) begin
                    state_d  = S_DONE;
                    result_d = it_res;
                    err_d    = it_err;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    prev_d  = result_q;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            op_d  = opcode;
            cnt_d = '0;
            acc_d = '0;
            x_d   = {{WIDTH{1'b0}}, a};
            y_d   = b;
            if (is_iter_op) begin
                state_d = S_ITER;
            end else begin
                state_d  = S_DONE;
                result_d = alu_res;
                err_d    = alu_err;
                if (opcode == OP_CLR) prev_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            prev_q   <= prev_d;
        end
    end

    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_ITER);
    assign result      = result_q;
    assign err         = err_q;
    assign prev_result = prev_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core: vector table through a scoreboard, plus
// hand sequences for prev_result, back-pressure, back-to-back and reset.
module tb_seq_alu_core;

    localparam int W = 16;

`ifdef SEQ_ALU_SAT_EN
    localparam logic [15:0] MUL_OVF = 16'hFFFF;
    localparam logic [15:0] ADD_OVF = 16'hFFFF;
    localparam logic [15:0] SUB_BRW = 16'h0000;
`else
    localparam logic [15:0] MUL_OVF = 16'h0D40;
    localparam logic [15:0] ADD_OVF = 16'h0000;
    localparam logic [15:0] SUB_BRW = 16'hFFFE;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   opcode = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] prev_result;
    logic         err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bcnt = 0;
    int ovcnt = 0;

    typedef struct {
        logic [15:0] res;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        e;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    seq_alu_core #(.WIDTH(16), .UNROLL(1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode(opcode),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .prev_result(prev_result),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (busy) bcnt++;
        if (out_valid) ovcnt++;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h expected none",
                         result);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("err", 32'(err), 32'(e.e));
                if (e.lat >= 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [15:0] res,
                         input logic e, input int lat);
        int n = 0;
        exp_t x;
        @(negedge clk);
        opcode   = op;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        x.res = res;
        x.e   = e;
        x.lat = lat;
        x.acc = cyc;
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        opcode   = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_prev(input string nm, input logic [15:0] exp);
        @(negedge clk);
        #1;
        chk(nm, 32'(prev_result), 32'(exp));
    endtask

    task automatic addv(input string nm, input logic [3:0] op,
                        input logic [15:0] aa, input logic [15:0] bb,
                        input logic [15:0] res, input logic e,
                        input int lat);
        vec_t v;
        v.nm  = nm;
        v.op  = op;
        v.a   = aa;
        v.b   = bb;
        v.res = res;
        v.e   = e;
        v.lat = lat;
        vt.push_back(v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int o0;
        exp_t x;

        addv("div",      4'd13, 16'd40000, 16'd5,     16'd8000,  1'b0, 17);
        addv("mod",      4'd8,  16'd15,    16'd9,     16'd6,     1'b0, 17);
        addv("mul_ovf",  4'd5,  16'd200,   16'd1000,  MUL_OVF,   1'b1, 17);
        addv("mul",      4'd5,  16'd300,   16'd200,   16'd60000, 1'b0, 17);
        addv("srl",      4'd6,  16'd32,    16'd5,     16'd1,     1'b0, 1);
        addv("sll",      4'd14, 16'd2,     16'd4,     16'd32,    1'b0, 1);
        addv("sll_low",  4'd14, 16'd1,     16'h0013,  16'd8,     1'b0, 1);
        addv("srl_zero", 4'd6,  16'hABCD,  16'h0010,  16'hABCD,  1'b0, 1);
        addv("div0",     4'd13, 16'd1234,  16'd0,     16'hFFFF,  1'b1, 1);
        addv("mod0",     4'd8,  16'd1234,  16'd0,     16'd1234,  1'b1, 1);
        addv("add_ovf",  4'd4,  16'hFFFF,  16'd1,     ADD_OVF,   1'b1, 1);
        addv("sub_brw",  4'd12, 16'd3,     16'd5,     SUB_BRW,   1'b1, 1);
        addv("add",      4'd4,  16'd100,   16'd23,    16'd123,   1'b0, 1);
        addv("or",       4'd2,  16'h00F0,  16'h0F00,  16'h0FF0,  1'b0, 1);
        addv("nand",     4'd9,  16'hFFFF,  16'h00FF,  16'hFF00,  1'b0, 1);
        addv("not",      4'd7,  16'h1234,  16'hFFFF,  16'hEDCB,  1'b0, 1);
        addv("nor",      4'd10, 16'h00F0,  16'h0F00,  16'hF00F,  1'b0, 1);
        addv("xnor",     4'd11, 16'hFF00,  16'h0F0F,  16'h0FF0,  1'b0, 1);

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_prev", 32'(prev_result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            b0 = bcnt;
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].e, vt[i].lat);
            drain();
            chk_prev({vt[i].nm, "_prev"}, vt[i].res);
            if (vt[i].lat == 17) chk({vt[i].nm, "_busy"}, 32'(bcnt - b0), 32'd16);
        end

        issue(4'd1, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0, 1);
        drain();
        chk_prev("and_prev", 16'h000F);
        issue(4'd0, 16'h5555, 16'hAAAA, 16'h000F, 1'b0, 1);
        drain();
        chk_prev("nop_prev", 16'h000F);
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'd15, 16'h1234, 16'h4321, 16'h0000, 1'b0, -1);
        @(negedge clk);
        #1;
        chk("clr_prev_at_accept", 32'(prev_result), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        chk_prev("clr_prev", 16'h0000);
        issue(4'd0, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1);
        drain();
        chk_prev("nop2_prev", 16'h0000);

        @(negedge clk);
        out_ready = 1'b0;
        issue(4'd3, 16'h1234, 16'h0F0F, 16'h1D3B, 1'b0, -1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("hold_result", 32'(result), 32'h1D3B);
            chk("hold_err", 32'(err), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        opcode    = 4'd4;
        a         = 16'd100;
        b         = 16'd23;
        in_valid  = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        x.res = 16'd123;
        x.e   = 1'b0;
        x.lat = 1;
        x.acc = cyc;
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk_prev("b2b_prev", 16'd123);

        issue(4'd13, 16'd40000, 16'd5, 16'd8000, 1'b0, -1);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_prev", 32'(prev_result), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        o0 = ovcnt;
        repeat (25) @(negedge clk);
        #2;
        chk("no_out_after_rst", 32'(ovcnt - o0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
